// File: rtl/irq_ctrl_if.sv
// ============================================================================
// Module  : irq_ctrl_if
// Brief   : CPU-side register and dispatch handshake bundle for irq_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface irq_ctrl_if;
  logic       cpu_sel_if;
  logic       cpu_sel_ie;
  logic       cpu_wr;
  logic [7:0] cpu_di;
  logic [7:0] cpu_do;
  logic       int_pending;
  logic       int_ack;
  logic [7:0] int_vector;
  logic       int_vec_valid;

  modport master (
    output cpu_sel_if, cpu_sel_ie, cpu_wr, cpu_di, int_ack,
    input  cpu_do, int_pending, int_vector, int_vec_valid
  );

  modport slave (
    input  cpu_sel_if, cpu_sel_ie, cpu_wr, cpu_di, int_ack,
    output cpu_do, int_pending, int_vector, int_vec_valid
  );
endinterface

`default_nettype wire

// File: rtl/irq_ctrl.sv
// ============================================================================
// Module  : irq_ctrl
// Brief   : IF/IE interrupt controller with CPU dispatch sequencer.
//           IRQ_CTRL_IE_PUSH_CANCEL_EN selects late (RESOLVE) priority sampling.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_ctrl #(
  parameter logic [7:0] VEC_BASE = 8'h40
) (
  input  wire logic   clk_sys,
  input  wire logic   reset,
  input  wire logic   ce,
  input  wire logic   irq_vblank,
  input  wire logic   irq_lcd,
  input  wire logic   irq_timer,
  input  wire logic   irq_serial,
  input  wire logic   irq_joypad,
  irq_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PUSH    = 2'd1,
    ST_RESOLVE = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;

  logic [4:0] if_r;
  logic [7:0] ie_r;
  logic [4:0] req_prev;
  logic [7:0] vec_r;
  logic       vec_valid_r;

  logic [4:0] req;
  logic       wr_if;
  logic       wr_ie;
  logic [4:0] if_wr_val;
  logic [7:0] ie_wr_val;
  logic [4:0] pend_now;
  logic [4:0] pick_onehot;
  logic [2:0] pick_idx;
  logic [7:0] vec_sel;
  logic       take;
  logic [4:0] clr_mask;
  logic [4:0] if_nxt;

  function automatic logic [2:0] lowest_idx(input logic [4:0] p);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (p[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  assign req   = {irq_joypad, irq_serial, irq_timer, irq_lcd, irq_vblank};
  assign wr_if = ce & bus.cpu_wr & bus.cpu_sel_if;
  assign wr_ie = ce & bus.cpu_wr & bus.cpu_sel_ie;

  // Same-ce CPU writes take effect before the dispatch pick and clear.
  assign if_wr_val   = wr_if ? bus.cpu_di[4:0] : if_r;
  assign ie_wr_val   = wr_ie ? bus.cpu_di      : ie_r;
  assign pend_now    = if_wr_val & ie_wr_val[4:0];
  assign pick_onehot = pend_now & (~pend_now + 5'd1);
  assign pick_idx    = lowest_idx(pend_now);
  assign vec_sel     = (|pend_now) ? (VEC_BASE + {2'b00, pick_idx, 3'b000}) : 8'h00;

`ifdef IRQ_CTRL_IE_PUSH_CANCEL_EN
  assign take = ce & (state == ST_RESOLVE);
`else
  assign take = ce & (state == ST_IDLE) & bus.int_ack;

  // Vector chosen at acknowledge, presented at RESOLVE.
  logic [7:0] vec_latched;
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      vec_latched <= 8'h00;
    end else if (take) begin
      vec_latched <= vec_sel;
    end
  end
`endif

  assign clr_mask = take ? pick_onehot : 5'b00000;
  // Source edges are applied last so a request is never lost to a write/clear.
  assign if_nxt   = (if_wr_val & ~clr_mask) | (req & ~req_prev);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (ce && bus.int_ack) begin
          state_nxt = ST_PUSH;
          cnt_nxt   = 3'd0;
        end
      end
      ST_PUSH: begin
        if (ce) begin
          cnt_nxt = cnt + 3'd1;
          if (cnt == 3'd7) state_nxt = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        if (ce) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      if_r        <= 5'b00000;
      ie_r        <= 8'h00;
      req_prev    <= 5'b00000;
      vec_r       <= 8'h00;
      vec_valid_r <= 1'b0;
    end else begin
      vec_valid_r <= 1'b0;
      if (ce) begin
        req_prev <= req;
        if_r     <= if_nxt;
        if (wr_ie) ie_r <= bus.cpu_di;
        if (state == ST_RESOLVE) begin
`ifdef IRQ_CTRL_IE_PUSH_CANCEL_EN
          vec_r <= vec_sel;
`else
          vec_r <= vec_latched;
`endif
          vec_valid_r <= 1'b1;
        end
      end
    end
  end

  assign bus.cpu_do        = bus.cpu_sel_if ? {3'b111, if_r} :
                             bus.cpu_sel_ie ? ie_r : 8'hFF;
  assign bus.int_pending   = |(if_r & ie_r[4:0]);
  assign bus.int_vector    = vec_r;
  assign bus.int_vec_valid = vec_valid_r;

endmodule

`default_nettype wire

// File: tb/tb_irq_ctrl.sv
// ============================================================================
// Module  : tb_irq_ctrl
// Brief   : Directed self-checking bench for irq_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irq_ctrl;
  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  logic ce      = 1'b0;
  logic irq_vblank = 1'b0, irq_lcd = 1'b0, irq_timer = 1'b0;
  logic irq_serial = 1'b0, irq_joypad = 1'b0;
  logic [7:0] rd;

  integer errors = 0;
  integer checks = 0;

  irq_ctrl_if bus();

  irq_ctrl #(.VEC_BASE(8'h40)) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ce         (ce),
    .irq_vblank (irq_vblank),
    .irq_lcd    (irq_lcd),
    .irq_timer  (irq_timer),
    .irq_serial (irq_serial),
    .irq_joypad (irq_joypad),
    .bus        (bus)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic ce_step();
    ce = 1'b1;
    @(posedge clk_sys);
    #1;
    ce = 1'b0;
    bus.cpu_wr  = 1'b0;
    bus.int_ack = 1'b0;
  endtask

  task automatic write_if(input logic [7:0] d);
    bus.cpu_sel_if = 1'b1; bus.cpu_sel_ie = 1'b0;
    bus.cpu_di = d; bus.cpu_wr = 1'b1;
    ce_step();
  endtask

  task automatic write_ie(input logic [7:0] d);
    bus.cpu_sel_if = 1'b0; bus.cpu_sel_ie = 1'b1;
    bus.cpu_di = d; bus.cpu_wr = 1'b1;
    ce_step();
  endtask

  task automatic read_if(output logic [7:0] v);
    bus.cpu_sel_if = 1'b1; bus.cpu_sel_ie = 1'b0;
    #1 v = bus.cpu_do;
  endtask

  task automatic read_ie(output logic [7:0] v);
    bus.cpu_sel_if = 1'b0; bus.cpu_sel_ie = 1'b1;
    #1 v = bus.cpu_do;
  endtask

  task automatic test_reset();
    #3;
    read_if(rd);
    checks++; if (rd !== 8'hE0) begin errors++; $display("FAIL reset_if got=%h exp=%h", rd, 8'hE0); end
    read_ie(rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL reset_ie got=%h exp=%h", rd, 8'h00); end
    checks++; if (bus.int_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got=%b exp=0", bus.int_pending); end
    checks++; if (bus.int_vector !== 8'h00) begin errors++; $display("FAIL reset_vector got=%h exp=00", bus.int_vector); end
    checks++; if (bus.int_vec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.int_vec_valid); end
    @(posedge clk_sys); @(posedge clk_sys); #1;
    reset = 1'b0;
  endtask

  task automatic test_timer();
    write_ie(8'h04);
    irq_timer = 1'b1;
    ce_step();
    irq_timer = 1'b0;
    read_if(rd);
    checks++; if (rd !== 8'hE4) begin errors++; $display("FAIL timer_if_set got=%h exp=E4", rd); end
    checks++; if (bus.int_pending !== 1'b1) begin errors++; $display("FAIL timer_pending got=%b exp=1", bus.int_pending); end
    bus.int_ack = 1'b1;
    ce_step();
    for (int i = 1; i <= 8; i++) begin
      ce_step();
      checks++; if (bus.int_vec_valid !== 1'b0) begin errors++; $display("FAIL timer_early_valid ce=%0d got=%b exp=0", i, bus.int_vec_valid); end
    end
    ce_step();
    checks++; if (bus.int_vec_valid !== 1'b1) begin errors++; $display("FAIL timer_valid got=%b exp=1", bus.int_vec_valid); end
    checks++; if (bus.int_vector !== 8'h50) begin errors++; $display("FAIL timer_vector got=%h exp=50", bus.int_vector); end
    read_if(rd);
    checks++; if (rd !== 8'hE0) begin errors++; $display("FAIL timer_if_clear got=%h exp=E0", rd); end
    @(posedge clk_sys); #1;
    checks++; if (bus.int_vec_valid !== 1'b0) begin errors++; $display("FAIL timer_valid_width got=%b exp=0", bus.int_vec_valid); end
  endtask

  task automatic test_priority();
    write_ie(8'h1F);
    write_if(8'h16);
    bus.int_ack = 1'b1;
    ce_step();
    for (int i = 0; i < 9; i++) ce_step();
    checks++; if (bus.int_vector !== 8'h48 || bus.int_vec_valid !== 1'b1) begin errors++; $display("FAIL prio_first got=%h/%b exp=48/1", bus.int_vector, bus.int_vec_valid); end
    read_if(rd);
    checks++; if (rd !== 8'hF4) begin errors++; $display("FAIL prio_if_after1 got=%h exp=F4", rd); end
    bus.int_ack = 1'b1;
    ce_step();
    for (int i = 0; i < 9; i++) ce_step();
    checks++; if (bus.int_vector !== 8'h50 || bus.int_vec_valid !== 1'b1) begin errors++; $display("FAIL prio_second got=%h/%b exp=50/1", bus.int_vector, bus.int_vec_valid); end
    read_if(rd);
    checks++; if (rd !== 8'hF0) begin errors++; $display("FAIL prio_if_after2 got=%h exp=F0", rd); end
  endtask

  task automatic test_cancel();
    logic [7:0] exp_vec, exp_if;
`ifdef IRQ_CTRL_IE_PUSH_CANCEL_EN
    exp_vec = 8'h00; exp_if = 8'hE4;
`else
    exp_vec = 8'h50; exp_if = 8'hE0;
`endif
    write_if(8'h04);
    write_ie(8'h04);
    bus.int_ack = 1'b1;
    ce_step();
    for (int i = 0; i < 3; i++) ce_step();
    write_ie(8'h00);
    for (int i = 0; i < 4; i++) ce_step();
    ce_step();
    checks++; if (bus.int_vec_valid !== 1'b1) begin errors++; $display("FAIL cancel_valid got=%b exp=1", bus.int_vec_valid); end
    checks++; if (bus.int_vector !== exp_vec) begin errors++; $display("FAIL cancel_vector got=%h exp=%h", bus.int_vector, exp_vec); end
    read_if(rd);
    checks++; if (rd !== exp_if) begin errors++; $display("FAIL cancel_if got=%h exp=%h", rd, exp_if); end
  endtask

  task automatic test_collision();
    write_if(8'h00);
    irq_timer = 1'b1;
    write_if(8'h00);
    irq_timer = 1'b0;
    read_if(rd);
    checks++; if (rd !== 8'hE4) begin errors++; $display("FAIL collision_if got=%h exp=E4", rd); end
    ce_step();
  endtask

  task automatic test_level();
    write_if(8'h00);
    irq_vblank = 1'b1;
    ce_step();
    read_if(rd);
    checks++; if (rd !== 8'hE1) begin errors++; $display("FAIL level_set got=%h exp=E1", rd); end
    for (int i = 0; i < 49; i++) ce_step();
    write_if(8'h00);
    for (int i = 0; i < 50; i++) ce_step();
    read_if(rd);
    checks++; if (rd !== 8'hE0) begin errors++; $display("FAIL level_stays_clear got=%h exp=E0", rd); end
    irq_vblank = 1'b0;
    ce_step();
    read_if(rd);
    checks++; if (rd !== 8'hE0) begin errors++; $display("FAIL level_fall got=%h exp=E0", rd); end
    irq_vblank = 1'b1;
    ce_step();
    read_if(rd);
    checks++; if (rd !== 8'hE1) begin errors++; $display("FAIL level_rise_again got=%h exp=E1", rd); end
    irq_vblank = 1'b0;
    ce_step();
  endtask

  task automatic test_back_to_back();
    write_ie(8'h03);
    write_if(8'h03);
    bus.int_ack = 1'b1;
    ce_step();
    ce_step(); ce_step();
    bus.int_ack = 1'b1;
    ce_step();
    for (int i = 0; i < 5; i++) ce_step();
    ce_step();
    checks++; if (bus.int_vector !== 8'h40 || bus.int_vec_valid !== 1'b1) begin errors++; $display("FAIL b2b_vector got=%h/%b exp=40/1", bus.int_vector, bus.int_vec_valid); end
    for (int i = 0; i < 12; i++) begin
      ce_step();
      checks++; if (bus.int_vec_valid !== 1'b0) begin errors++; $display("FAIL b2b_spurious_valid ce=%0d got=%b exp=0", i, bus.int_vec_valid); end
    end
    read_if(rd);
    checks++; if (rd !== 8'hE2) begin errors++; $display("FAIL b2b_if got=%h exp=E2", rd); end
  endtask

  task automatic test_reset_mid_dispatch();
    write_if(8'h01);
    write_ie(8'h01);
    bus.int_ack = 1'b1;
    ce_step();
    for (int i = 0; i < 4; i++) ce_step();
    reset = 1'b1;
    #1;
    checks++; if (bus.int_vec_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", bus.int_vec_valid); end
    checks++; if (bus.int_vector !== 8'h00) begin errors++; $display("FAIL midrst_vector got=%h exp=00", bus.int_vector); end
    checks++; if (bus.int_pending !== 1'b0) begin errors++; $display("FAIL midrst_pending got=%b exp=0", bus.int_pending); end
    read_if(rd);
    checks++; if (rd !== 8'hE0) begin errors++; $display("FAIL midrst_if got=%h exp=E0", rd); end
    @(posedge clk_sys); @(posedge clk_sys); #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ce_step();
      checks++; if (bus.int_vec_valid !== 1'b0) begin errors++; $display("FAIL midrst_late_valid ce=%0d got=%b exp=0", i, bus.int_vec_valid); end
    end
    read_if(rd);
    checks++; if (rd !== 8'hE0) begin errors++; $display("FAIL postrst_if got=%h exp=E0", rd); end
    read_ie(rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL postrst_ie got=%h exp=00", rd); end
  endtask

  initial begin
    bus.cpu_sel_if = 1'b0;
    bus.cpu_sel_ie = 1'b0;
    bus.cpu_wr     = 1'b0;
    bus.cpu_di     = 8'h00;
    bus.int_ack    = 1'b0;
    test_reset();
    test_timer();
    test_priority();
    test_cancel();
    test_collision();
    test_level();
    test_back_to_back();
    test_reset_mid_dispatch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
